bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and slave selector for the serial system bus. Grants the shared bus to one of two masters using round-robin priority. Decodes a slave-ID prefix shifted in serially on the address line, then drives a one-hot select to the addressed slave until that slave reports completion. It also enforces an idle timeout so a stalled master cannot hold the bus.

## Interface
- NUM_SLAVES, 3, number of attached slaves; legal IDs 0..NUM_SLAVES-1
- SID_BITS, 2, width of serial slave-ID prefix; must satisfy 2^SID_BITS >= NUM_SLAVES
- TIMEOUT, 255, idle cycles allowed in SID/CONNECT before forced release; counter width clog2(TIMEOUT+1)
- clk  in  1  single bus clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m1_req  in  1  master 1 bus request, level
- m2_req  in  1  master 2 bus request, level
- m1_grant  out  1  master 1 owns bus
- m2_grant  out  1  master 2 owns bus
- master_valid  in  1  granted master's valid, already muxed by the bus
- rx_address  in  1  granted master's serial address line, already muxed
- tx_done  in  1  one-cycle pulse from selected slave: transaction finished
- slave_sel  out  NUM_SLAVES  one-hot slave select
- bus_busy  out  1  high in every state except IDLE
- sid_err  out  1  one-cycle pulse: decoded ID >= NUM_SLAVES
- timeout_err  out  1  one-cycle pulse: idle timeout fired

## Operation
- States: IDLE, SID, CONNECT, RELEASE.
- IDLE:
  - If any request is present, grant per round-robin and go to SID.
  - If both request, the master not granted last wins.
  - `last` resets to master 2, so master 1 wins the first tie.
- SID:
  - Grant held.
  - On each cycle with master_valid=1, shift rx_address into sid_reg MSB-first and increment bit_cnt.
  - After SID_BITS bits:
    - ID < NUM_SLAVES: go to CONNECT.
    - ID >= NUM_SLAVES: pulse sid_err and go to RELEASE.
- CONNECT:
  - Grant held; slave_sel[sid_reg]=1.
  - rx_address is ignored by the arbiter.
  - tx_done=1 → RELEASE.
- RELEASE:
  - Grant and slave_sel low.
  - Update `last`, clear bit_cnt and sid_reg, go to IDLE.
- Request dropped by the granted master in SID or CONNECT → RELEASE, with no error pulse.
- Timeout:
  - Counter clears on entry to SID/CONNECT and on every cycle with master_valid=1 or tx_done=1.
  - It increments otherwise.
  - Reaching TIMEOUT pulses timeout_err and forces RELEASE.
- Priority within a cycle: tx_done > request drop > timeout > SID shift.
- In IDLE, tx_done and master_valid are ignored.
- Grant outputs are never both high. slave_sel is nonzero only in CONNECT.
- Reset (any time, including mid-transaction):
  - Immediately: grants=0, slave_sel=0, bus_busy=0, sid_err=0, timeout_err=0.
  - State IDLE, `last`=master 2, counters cleared.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at edge k → grant high from edge k (cycle k+1).
- The first SID bit may be sampled at edge k+1.
- Last SID bit sampled at edge j → slave_sel high from edge j; select latency 1 cycle.
- tx_done sampled at edge d → grant and slave_sel low from edge d.
- RELEASE lasts 1 cycle; IDLE lasts at least 1 cycle.
- Next grant appears earliest at edge d+2, so the minimum no-grant gap is 2 cycles.
- Error pulses are exactly 1 cycle and coincide with entry to RELEASE.
- Worst-case hold with a silent master: TIMEOUT+1 cycles after the last activity.

## Structure
- Shared bus package holds:
  - State encoding constants (IDLE=0, SID=1, CONNECT=2, RELEASE=3).
  - Default NUM_SLAVES and SID_BITS, shared with the bus mux and slave address decode.
- One natural sub-module: rr_pick. It is a two-requester round-robin selector: inputs req[1:0] and last; output a one-hot pick. It is purely combinational and reusable when a third master is added.

## Test plan
- Single request, ID 1:
  - Stimulus: m1_req=1 at edge 0; serial bits 0,1 with master_valid; tx_done pulse 5 cycles later.
  - Response: m1_grant from edge 0; slave_sel=3'b010 from edge 2; all low one edge after tx_done.
- Tie after reset:
  - Stimulus: both requests held.
  - Response: m1 granted first; after its tx_done, m2 granted 2 cycles later; then m1 again.
- Invalid ID:
  - Stimulus: bits 1,1 with NUM_SLAVES=3.
  - Response: sid_err pulse 1 cycle after the last bit; slave_sel never asserted; grant dropped.
- Timeout:
  - Stimulus: TIMEOUT=8; grant m2, send ID 0, then hold master_valid=0 and no tx_done.
  - Response: timeout_err pulses on the 9th idle cycle; grant and slave_sel drop together.
- Reset mid-CONNECT:
  - Stimulus: deassert reset asynchronously between edges.
  - Response: grants and slave_sel go 0 immediately. After release, a simultaneous request from both masters grants m1.
- Request drop:
  - Stimulus: m1_req falls after 1 SID bit.
  - Response: grant low next edge; no error pulse; sid state cleared, verified by the next grant decoding its ID correctly.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared serial-bus definitions: FSM state encoding, master identifiers and
// default geometry used by the arbiter, the bus mux and the slave address decode.
package bus_arbiter_pkg;

  localparam int DEF_NUM_SLAVES = 3;
  localparam int DEF_SID_BITS   = 2;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SID     = 2'd1,
    CONNECT = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    MASTER_1 = 1'b0,
    MASTER_2 = 1'b1
  } master_e;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Two-requester round-robin selector: returns a one-hot pick, favouring the
// requester that was not served last when both ask at once.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_e    last,
  output logic [1:0] pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = (last == MASTER_2) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with serial slave-ID decode, one-hot slave
// select and an idle timeout that forces a stalled master off the bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int SID_BITS   = DEF_SID_BITS,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_req,
  input  logic                  m2_req,
  output logic                  m1_grant,
  output logic                  m2_grant,
  input  logic                  master_valid,
  input  logic                  rx_address,
  input  logic                  tx_done,
  output logic [NUM_SLAVES-1:0] slave_sel,
  output logic                  bus_busy,
  output logic                  sid_err,
  output logic                  timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int CNT_W = $clog2(SID_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SID_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

  state_e                state_q,   state_n;
  master_e               last_q,    last_n;
  master_e               owner_q,   owner_n;
  logic [SID_BITS-1:0]   sid_q,     sid_n;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_n;
  logic [TO_W-1:0]       to_cnt_q,  to_cnt_n;
  logic [1:0]            grant_q,   grant_n;
  logic [NUM_SLAVES-1:0] sel_q,     sel_n;
  logic                  busy_q,    busy_n;
  logic                  sid_err_q, sid_err_n;
  logic                  to_err_q,  to_err_n;

  logic [1:0]          pick;
  logic [SID_BITS-1:0] sid_shift;
  logic                owner_req;
  logic                timed_out;
  logic                activity;

  rr_pick u_rr_pick (
    .req  ({m2_req, m1_req}),
    .last (last_q),
    .pick (pick)
  );

  assign owner_req = (owner_q == MASTER_2) ? m2_req : m1_req;
  assign timed_out = (to_cnt_q == TO_LIMIT);
  assign activity  = master_valid || tx_done;
  assign sid_shift = SID_BITS'({sid_q, rx_address});

  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path can infer a latch.
    state_n   = state_q;
    last_n    = last_q;
    owner_n   = owner_q;
    sid_n     = sid_q;
    bit_cnt_n = bit_cnt_q;
    to_cnt_n  = '0;
    grant_n   = grant_q;
    sel_n     = sel_q;
    sid_err_n = 1'b0;
    to_err_n  = 1'b0;

    case (state_q)
      IDLE: begin
        grant_n = '0;
        sel_n   = '0;
        if (|pick) begin
          state_n = SID;
          grant_n = pick;
          owner_n = pick[1] ? MASTER_2 : MASTER_1;
        end
      end

      SID: begin
        to_cnt_n = activity ? '0 : to_cnt_q + 1'b1;
        if (tx_done || !owner_req) begin
          state_n = RELEASE;
        end else if (timed_out) begin
          state_n  = RELEASE;
          to_err_n = 1'b1;
        end else if (master_valid) begin
          sid_n     = sid_shift;
          bit_cnt_n = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            if (int'(sid_shift) < NUM_SLAVES) begin
              state_n  = CONNECT;
              sel_n    = NUM_SLAVES'(1) << sid_shift;
              to_cnt_n = '0;
            end else begin
              state_n   = RELEASE;
              sid_err_n = 1'b1;
            end
          end
        end
      end

      CONNECT: begin
        to_cnt_n = activity ? '0 : to_cnt_q + 1'b1;
        if (tx_done || !owner_req) begin
          state_n = RELEASE;
        end else if (timed_out) begin
          state_n  = RELEASE;
          to_err_n = 1'b1;
        end
      end

      RELEASE: begin
        state_n   = IDLE;
        last_n    = owner_q;
        sid_n     = '0;
        bit_cnt_n = '0;
      end

      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state, so leaving the bus drops them on the same edge.
    if (state_n == RELEASE) begin
      grant_n = '0;
      sel_n   = '0;
    end
    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= MASTER_2;
      owner_q   <= MASTER_1;
      sid_q     <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      sid_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      last_q    <= last_n;
      owner_q   <= owner_n;
      sid_q     <= sid_n;
      bit_cnt_q <= bit_cnt_n;
      to_cnt_q  <= to_cnt_n;
      grant_q   <= grant_n;
      sel_q     <= sel_n;
      busy_q    <= busy_n;
      sid_err_q <= sid_err_n;
      to_err_q  <= to_err_n;
    end
  end

  assign m1_grant    = grant_q[0];
  assign m2_grant    = grant_q[1];
  assign slave_sel   = sel_q;
  assign bus_busy    = busy_q;
  assign sid_err     = sid_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: round-robin ties, ID decode, invalid ID,
// request drop, idle timeout and asynchronous reset in the middle of a transfer.
module tb_bus_arbiter;

  localparam int NUM_SLAVES = 3;
  localparam int SID_BITS   = 2;
  localparam int TIMEOUT    = 8;

  logic clk = 1'b0;
  logic reset;
  logic m1_req, m2_req;
  logic m1_grant, m2_grant;
  logic master_valid, rx_address, tx_done;
  logic [NUM_SLAVES-1:0] slave_sel;
  logic bus_busy, sid_err, timeout_err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_SLAVES (NUM_SLAVES),
    .SID_BITS   (SID_BITS),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_req       (m1_req),
    .m2_req       (m2_req),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .master_valid (master_valid),
    .rx_address   (rx_address),
    .tx_done      (tx_done),
    .slave_sel    (slave_sel),
    .bus_busy     (bus_busy),
    .sid_err      (sid_err),
    .timeout_err  (timeout_err)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector layout: {m1_grant, m2_grant} _ slave_sel[2:0] _ {bus_busy, sid_err, timeout_err}
  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {m1_grant, m2_grant, slave_sel, bus_busy, sid_err, timeout_err};
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    m1_req = 1'b0; m2_req = 1'b0;
    master_valid = 1'b0; rx_address = 1'b0; tx_done = 1'b0;
    tick(); tick();
    check("reset_state", 8'b00_000_000);
    reset = 1'b1;
    tick();
    check("idle_after_reset", 8'b00_000_000);

    // Tie straight after reset: m1 first, then m2, then m1 again.
    m1_req = 1'b1; m2_req = 1'b1;
    tick();
    check("tie_first_m1", 8'b10_000_100);
    master_valid = 1'b1; rx_address = 1'b0;
    tick();
    check("tie_m1_sid", 8'b10_000_100);
    rx_address = 1'b0;
    tick();
    master_valid = 1'b0;
    check("tie_m1_sel0", 8'b10_001_100);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("tie_m1_release", 8'b00_000_100);
    tick();
    check("tie_gap_idle", 8'b00_000_000);
    tick();
    check("tie_m2_next", 8'b01_000_100);
    master_valid = 1'b1; rx_address = 1'b1;
    tick();
    rx_address = 1'b0;
    tick();
    master_valid = 1'b0;
    check("tie_m2_sel2", 8'b01_100_100);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("tie_m2_release", 8'b00_000_100);
    tick();
    tick();
    check("tie_m1_again", 8'b10_000_100);

    // m1 drops its request after one SID bit.
    m2_req = 1'b0;
    master_valid = 1'b1; rx_address = 1'b1;
    tick();
    check("drop_sid_bit", 8'b10_000_100);
    m1_req = 1'b0; master_valid = 1'b0;
    tick();
    check("drop_release", 8'b00_000_100);
    tick();
    check("drop_idle", 8'b00_000_000);

    // Single request, ID 1; a stale SID bit would finish decode one bit early.
    m1_req = 1'b1;
    tick();
    check("id1_grant", 8'b10_000_100);
    master_valid = 1'b1; rx_address = 1'b0;
    tick();
    check("id1_first_bit", 8'b10_000_100);
    rx_address = 1'b1;
    tick();
    master_valid = 1'b0;
    check("id1_sel", 8'b10_010_100);
    repeat (4) tick();
    check("id1_hold", 8'b10_010_100);
    tx_done = 1'b1; m1_req = 1'b0;
    tick();
    tx_done = 1'b0;
    check("id1_release", 8'b00_000_100);
    tick();
    check("id1_idle", 8'b00_000_000);

    // Invalid ID 3 with three slaves.
    m1_req = 1'b1;
    tick();
    check("badid_grant", 8'b10_000_100);
    master_valid = 1'b1; rx_address = 1'b1;
    tick();
    check("badid_first_bit", 8'b10_000_100);
    tick();
    master_valid = 1'b0; m1_req = 1'b0;
    check("badid_err", 8'b00_000_110);
    tick();
    check("badid_idle", 8'b00_000_000);

    // Timeout: m2 connects to slave 0 and then goes silent.
    m2_req = 1'b1;
    tick();
    check("to_grant_m2", 8'b01_000_100);
    master_valid = 1'b1; rx_address = 1'b0;
    tick();
    tick();
    master_valid = 1'b0;
    check("to_sel0", 8'b01_001_100);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), 8'b01_001_100);
    end
    tick();
    m2_req = 1'b0;
    check("to_fire", 8'b00_000_101);
    tick();
    check("to_idle", 8'b00_000_000);

    // Asynchronous reset while m1 is connected to slave 2.
    m1_req = 1'b1;
    tick();
    check("rst_grant", 8'b10_000_100);
    master_valid = 1'b1; rx_address = 1'b1;
    tick();
    rx_address = 1'b0;
    tick();
    master_valid = 1'b0;
    check("rst_sel2", 8'b10_100_100);
    m2_req = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst_async", 8'b00_000_000);
    #2 reset = 1'b1;
    tick();
    check("rst_tie_m1", 8'b10_000_100);
    m1_req = 1'b0; m2_req = 1'b0;
    tick();
    check("final_release", 8'b00_000_100);
    tick();
    check("final_idle", 8'b00_000_000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
